// File: rtl/csr_control_if.sv
// Decode-stage signal bundle for the Zicsr control overlay: instruction fields and base
// control selects in, CSR enables and final datapath selects out.
interface csr_control_if;
  logic [6:0] opcode_decode;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rd;
  logic [1:0] extend_sel_base;
  logic [1:0] operand_A_sel_base;
  logic       operand_B_sel_base;
  logic [5:0] ALU_operation_base;
  logic       regWrite_base;
  logic       scan;

  logic       CSR_read_en;
  logic       CSR_write_en;
  logic       CSR_set_en;
  logic       CSR_clear_en;
  logic [1:0] extend_sel;
  logic [1:0] operand_A_sel;
  logic       operand_B_sel;
  logic [5:0] ALU_operation;
  logic       regWrite;

  modport master (
    output opcode_decode, funct3, rs1, rd, extend_sel_base, operand_A_sel_base,
           operand_B_sel_base, ALU_operation_base, regWrite_base, scan,
    input  CSR_read_en, CSR_write_en, CSR_set_en, CSR_clear_en, extend_sel,
           operand_A_sel, operand_B_sel, ALU_operation, regWrite
  );

  modport slave (
    input  opcode_decode, funct3, rs1, rd, extend_sel_base, operand_A_sel_base,
           operand_B_sel_base, ALU_operation_base, regWrite_base, scan,
    output CSR_read_en, CSR_write_en, CSR_set_en, CSR_clear_en, extend_sel,
           operand_A_sel, operand_B_sel, ALU_operation, regWrite
  );
endinterface

// File: rtl/csr_control.sv
// Zicsr decode overlay: recognises CSRRW/S/C(I), drives CSR-file enables and overrides
// the base datapath selects; a free-running cycle counter gates a simulation scan report.
module csr_control #(
  parameter int          CORE            = 0,
  parameter logic [31:0] SCAN_CYCLES_MIN = 32'd0,
  parameter logic [31:0] SCAN_CYCLES_MAX = 32'd1000
) (
  input  logic          clock,
  input  logic          reset,
  csr_control_if.slave  csr
);
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic        csr_op;
  logic        imm;
  logic        rw;
  logic        rs;
  logic        rc;
  logic        rs1_nz;
  logic        rd_nz;
  logic [31:0] cycle_count_reg;
  logic        scan_window;

  assign csr_op = (csr.opcode_decode == SYSTEM) && (csr.funct3[1:0] != 2'b00);
  assign imm    = csr.funct3[2];
  assign rw     = (csr.funct3[1:0] == 2'b01);
  assign rs     = (csr.funct3[1:0] == 2'b10);
  assign rc     = (csr.funct3[1:0] == 2'b11);
  assign rs1_nz = (csr.rs1 != 5'd0);
  assign rd_nz  = (csr.rd != 5'd0);

  // Explicit if/else keeps X on the base inputs from leaking out while csr_op is true.
  always_comb begin
    csr.CSR_read_en   = 1'b0;
    csr.CSR_write_en  = 1'b0;
    csr.CSR_set_en    = 1'b0;
    csr.CSR_clear_en  = 1'b0;
    csr.extend_sel    = csr.extend_sel_base;
    csr.operand_A_sel = csr.operand_A_sel_base;
    csr.operand_B_sel = csr.operand_B_sel_base;
    csr.ALU_operation = csr.ALU_operation_base;
    csr.regWrite      = csr.regWrite_base;
    if (csr_op) begin
      csr.CSR_read_en  = rs | rc | (rw & rd_nz);
      csr.CSR_write_en = rw;
      csr.CSR_set_en   = rs & rs1_nz;
      csr.CSR_clear_en = rc & rs1_nz;
      csr.regWrite     = rd_nz;
      if (imm) begin
        csr.extend_sel    = 2'd2;
        csr.operand_A_sel = 2'd3;
        csr.operand_B_sel = 1'b1;
        csr.ALU_operation = 6'd0;
      end else begin
        csr.extend_sel    = 2'd0;
        csr.operand_A_sel = 2'd0;
        csr.operand_B_sel = 1'b0;
        csr.ALU_operation = 6'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count_reg <= 32'd0;
    end else begin
      cycle_count_reg <= cycle_count_reg + 32'd1;
    end
  end

  // The leading 1 keeps the lower-bound compare meaningful when the minimum is zero.
  assign scan_window = csr.scan
                    && ({1'b1, cycle_count_reg} >= {1'b1, SCAN_CYCLES_MIN})
                    && (cycle_count_reg <= SCAN_CYCLES_MAX);

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (scan_window) begin
      $display("[scan] core=%0d cycle=%0d op=%b f3=%b rs1=%0d rd=%0d base(ext=%0d a=%0d b=%0d alu=%0d rw=%0d) rd_en=%0d wr_en=%0d set_en=%0d clr_en=%0d ext=%0d a=%0d b=%0d alu=%0d rw=%0d",
               CORE, cycle_count_reg, csr.opcode_decode, csr.funct3, csr.rs1, csr.rd,
               csr.extend_sel_base, csr.operand_A_sel_base, csr.operand_B_sel_base,
               csr.ALU_operation_base, csr.regWrite_base,
               csr.CSR_read_en, csr.CSR_write_en, csr.CSR_set_en, csr.CSR_clear_en,
               csr.extend_sel, csr.operand_A_sel, csr.operand_B_sel,
               csr.ALU_operation, csr.regWrite);
    end
  end
`endif
endmodule

// File: tb/tb_csr_control.sv
// Directed bench for csr_control: decode vectors, asynchronous counter reset, scan window edges.
module tb_csr_control;
  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  csr_control_if csr ();

  csr_control #(
    .CORE            (0),
    .SCAN_CYCLES_MIN (32'd0),
    .SCAN_CYCLES_MAX (32'd1000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .csr   (csr.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic [1:0] ext_b;
    logic [1:0] a_b;
    logic       b_b;
    logic [5:0] alu_b;
    logic       rw_b;
    logic [15:0] exp;
  } vec_t;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end else begin
      $display("[TB] ok   %s: %h", tag, obs);
    end
  endtask

  // {read, write, set, clear, extend[1:0], A[1:0], B, ALU[5:0], regWrite}
  function automatic logic [15:0] pk(input logic r, input logic w, input logic s, input logic c,
                                     input logic [1:0] e, input logic [1:0] a, input logic b,
                                     input logic [5:0] alu, input logic rw);
    return {r, w, s, c, e, a, b, alu, rw};
  endfunction

  function automatic logic [15:0] outs();
    return {csr.CSR_read_en, csr.CSR_write_en, csr.CSR_set_en, csr.CSR_clear_en,
            csr.extend_sel, csr.operand_A_sel, csr.operand_B_sel, csr.ALU_operation,
            csr.regWrite};
  endfunction

  task automatic apply(input vec_t v);
    csr.opcode_decode      = v.op;
    csr.funct3             = v.f3;
    csr.rs1                = v.rs1;
    csr.rd                 = v.rd;
    csr.extend_sel_base    = v.ext_b;
    csr.operand_A_sel_base = v.a_b;
    csr.operand_B_sel_base = v.b_b;
    csr.ALU_operation_base = v.alu_b;
    csr.regWrite_base      = v.rw_b;
  endtask

  localparam logic [6:0] SYS = 7'b1110011;
  localparam logic [6:0] RTY = 7'b0110011;

  vec_t vecs[12];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    // CSR forms carry X on the base selects to show they never reach the outputs.
    vecs[0]  = '{"csrrw",        SYS, 3'b001, 5'd1, 5'd1, 'x, 'x, 'x, 'x, 'x, pk(1,1,0,0,2'd0,2'd0,0,6'd1,1)};
    vecs[1]  = '{"csrrs",        SYS, 3'b010, 5'd1, 5'd1, 'x, 'x, 'x, 'x, 'x, pk(1,0,1,0,2'd0,2'd0,0,6'd1,1)};
    vecs[2]  = '{"csrrc",        SYS, 3'b011, 5'd1, 5'd1, 'x, 'x, 'x, 'x, 'x, pk(1,0,0,1,2'd0,2'd0,0,6'd1,1)};
    vecs[3]  = '{"csrrc_rs1z",   SYS, 3'b011, 5'd0, 5'd1, 'x, 'x, 'x, 'x, 'x, pk(1,0,0,0,2'd0,2'd0,0,6'd1,1)};
    vecs[4]  = '{"csrrwi",       SYS, 3'b101, 5'd1, 5'd1, 'x, 'x, 'x, 'x, 'x, pk(1,1,0,0,2'd2,2'd3,1,6'd0,1)};
    vecs[5]  = '{"csrrwi_rdz",   SYS, 3'b101, 5'd1, 5'd0, 'x, 'x, 'x, 'x, 'x, pk(0,1,0,0,2'd2,2'd3,1,6'd0,0)};
    vecs[6]  = '{"csrrw_rz",     SYS, 3'b001, 5'd0, 5'd0, 'x, 'x, 'x, 'x, 'x, pk(0,1,0,0,2'd0,2'd0,0,6'd1,0)};
    vecs[7]  = '{"csrrsi_uz",    SYS, 3'b110, 5'd0, 5'd5, 'x, 'x, 'x, 'x, 'x, pk(1,0,0,0,2'd2,2'd3,1,6'd0,1)};
    vecs[8]  = '{"csrrci",       SYS, 3'b111, 5'd3, 5'd7, 'x, 'x, 'x, 'x, 'x, pk(1,0,0,1,2'd2,2'd3,1,6'd0,1)};
    vecs[9]  = '{"rtype_pass",   RTY, 3'b001, 5'd1, 5'd1, 2'd1, 2'd2, 1'b1, 6'd5, 1'b1, pk(0,0,0,0,2'd1,2'd2,1,6'd5,1)};
    vecs[10] = '{"sys000_pass",  SYS, 3'b000, 5'd1, 5'd1, 2'd1, 2'd2, 1'b1, 6'd5, 1'b1, pk(0,0,0,0,2'd1,2'd2,1,6'd5,1)};
    vecs[11] = '{"sys100_pass",  SYS, 3'b100, 5'd9, 5'd4, 2'd3, 2'd1, 1'b0, 6'd42, 1'b0, pk(0,0,0,0,2'd3,2'd1,0,6'd42,0)};

    csr.scan = 1'b0;
    reset    = 1'b0;
    apply(vecs[0]);
    #1;
    check_eq("reset_cnt0", dut.cycle_count_reg, 32'd0);
    check_eq("dec_in_reset", {16'd0, outs()}, {16'd0, vecs[0].exp});

    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      check_eq($sformatf("cnt_%0d", k), dut.cycle_count_reg, k);
    end

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      apply(vecs[i]);
      #1;
      check_eq(vecs[i].tag, {16'd0, outs()}, {16'd0, vecs[i].exp});
    end

    // Reset mid-cycle: counter clears at once, decode is unaffected.
    @(negedge clock);
    apply(vecs[4]);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_clr", dut.cycle_count_reg, 32'd0);
    check_eq("dec_mid_reset", {16'd0, outs()}, {16'd0, vecs[4].exp});
    @(posedge clock);
    #1;
    check_eq("held_in_reset", dut.cycle_count_reg, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      check_eq($sformatf("recount_%0d", k), dut.cycle_count_reg, k);
    end

    // Walk up to the scan window's upper edge with the report disabled.
    repeat (995) @(posedge clock);
    #1;
    check_eq("cnt_998", dut.cycle_count_reg, 32'd998);
    check_eq("win_scan_off", {31'd0, dut.scan_window}, 32'd0);
    csr.scan = 1'b1;
    #1;
    check_eq("win_998", {31'd0, dut.scan_window}, 32'd1);
    @(posedge clock);
    #1;
    check_eq("win_999", {31'd0, dut.scan_window}, 32'd1);
    @(posedge clock);
    #1;
    check_eq("win_1000", {31'd0, dut.scan_window}, 32'd1);
    @(posedge clock);
    #1;
    check_eq("cnt_1001", dut.cycle_count_reg, 32'd1001);
    check_eq("win_1001", {31'd0, dut.scan_window}, 32'd0);
    csr.scan = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/csr_control.md
# csr_control

Combinational decode overlay for RISC-V Zicsr instructions in the base core's decode stage. It recognizes CSRRW/CSRRS/CSRRC and their immediate forms, then generates the CSR-file read/write/set/clear enables. For those instructions it overrides the base control unit's datapath selects; for all other instructions it passes them through unchanged. A free-running cycle counter supports a simulation-only scan report.

## Interface
Parameters:
- CORE, 0, core index printed in scan reports.
- SCAN_CYCLES_MIN, 0, first cycle (inclusive) on which scan reports print.
- SCAN_CYCLES_MAX, 1000, last cycle (inclusive) on which scan reports print.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low; clears cycle counter.
- opcode_decode  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- rs1  in  5  rs1 field (uimm for immediate forms).
- rd  in  5  destination register field.
- extend_sel_base  in  2  base control unit's extend select.
- operand_A_sel_base  in  2  base control unit's operand A select.
- operand_B_sel_base  in  1  base control unit's operand B select.
- ALU_operation_base  in  6  base control unit's ALU code.
- regWrite_base  in  1  base control unit's register-write enable.
- CSR_read_en  out  1  read CSR.
- CSR_write_en  out  1  overwrite CSR.
- CSR_set_en  out  1  set CSR bits.
- CSR_clear_en  out  1  clear CSR bits.
- extend_sel  out  2  final extend select.
- operand_A_sel  out  2  final operand A select.
- operand_B_sel  out  1  final operand B select.
- ALU_operation  out  6  final ALU code.
- regWrite  out  1  final register-write enable.
- scan  in  1  enables the simulation scan report.

## Operation
- SYSTEM = 7'b1110011. csr_op = (opcode_decode == SYSTEM) & (funct3[1:0] != 2'b00).
  - imm = funct3[2].
  - rw = funct3[1:0]==01; rs = 10; rc = 11.
- When csr_op is true:
  - CSR_read_en = rs | rc | (rw & rd != 0).
  - CSR_write_en = rw. This holds regardless of rs1/uimm.
  - CSR_set_en = rs & (rs1 != 0).
  - CSR_clear_en = rc & (rs1 != 0).
  - regWrite = (rd != 0).
- Register forms (imm=0) drive:
  - extend_sel = 0.
  - operand_A_sel = 0, selecting rs1.
  - operand_B_sel = 0.
  - ALU_operation = 6'd1, the pass-operand-A code.
- Immediate forms (imm=1) drive:
  - extend_sel = 2, zero-extending the 5-bit uimm.
  - operand_A_sel = 3, selecting zero.
  - operand_B_sel = 1, selecting the immediate.
  - ALU_operation = 6'd0 (ADD), so the result is the uimm.
- Otherwise, including SYSTEM with funct3 000 or 100:
  - All four CSR enables are 0.
  - extend_sel, operand_A_sel, operand_B_sel, ALU_operation and regWrite equal their _base inputs.
- Every output is a pure function of the current inputs. X on an _base input must not propagate while csr_op is true.
- Cycle counter:
  - 32-bit; increments every rising clock edge; wraps modulo 2^32.
- Scan report:
  - Printed with $display when scan==1 and SCAN_CYCLES_MIN <= counter <= SCAN_CYCLES_MAX.
  - Contents: CORE, the counter value, and all inputs and outputs.
  - Not synthesized.

## Timing
- Decode path is combinational, zero latency. Outputs settle within the same cycle that inputs change.
- Reset affects only the cycle counter:
  - Asserting reset (low) forces the counter to 0 immediately, without waiting for a clock edge.
  - Counting resumes on the first rising edge after reset deasserts.
- Outputs have no reset value; during reset they still follow the decode equations.
- Reset asserted mid-operation has no effect on decode outputs.
- Scan report is sampled on each rising clock edge.

## Test plan
- SYSTEM, funct3=001, rs1=1, rd=1 (CSRRW) -> read=1, write=1, set=0, clear=0, extend=0, A=0, B=0, ALU=1, regWrite=1.
- funct3=010, rs1=1, rd=1 (CSRRS) -> read=1, write=0, set=1, clear=0, ALU=1, regWrite=1. funct3=011 with the same fields -> clear=1, set=0.
- CSRRC, rs1=0, rd=1 -> read=1, all other enables 0, ALU=1, regWrite=1.
- CSRRWI (funct3=101), rs1=1, rd=1 -> read=1, write=1, extend=2, A=3, B=1, ALU=0, regWrite=1. Same with rd=0 -> read=0, regWrite=0, write=1.
- R_TYPE opcode 0110011 with base extend=1, A=2, B=1, ALU=5, regWrite=1 -> outputs equal base values, all CSR enables 0. Also drive SYSTEM with funct3=000 -> same pass-through.
- Assert reset (low) mid-run -> counter reads 0 immediately, then counts 1, 2, … after release. With scan=1 and MIN=0, MAX=1000 -> a report prints every cycle in the window and none after counter 1000.
